noc_local_ingress: RTL and testbench

NOC_LOCAL_INGRESS -- requirements
Module: noc_local_ingress

---
 rtl/noc_local_ingress_if.sv | 33 +++
 rtl/noc_local_ingress.sv | 78 +++++++
 tb/tb_noc_local_ingress.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/noc_local_ingress_if.sv
// Local ingress port bundle: transmitter-side flit input plus downstream/status outputs.
interface noc_local_ingress_if #(
  parameter int unsigned HDR_SZ  = 2,
  parameter int unsigned PL_SZ   = 16,
  parameter int unsigned ADDR_SZ = 4,
  parameter int unsigned DEPTH   = 4
);
  localparam int unsigned W  = HDR_SZ + PL_SZ + ADDR_SZ;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [W-1:0]       item_in;
  logic               req;
  logic               channel_busy;
  logic [W-2:0]       out_flit;
  logic [ADDR_SZ-1:0] out_dest;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         parity_errs;
  logic [3:0]         drop_cnt;
  logic [LW-1:0]      level;

  // Transmitter / downstream side
  modport master (
    output item_in, req, out_ready,
    input  channel_busy, out_flit, out_dest, out_valid, parity_errs, drop_cnt, level
  );

  // Ingress block side
  modport slave (
    input  item_in, req, out_ready,
    output channel_busy, out_flit, out_dest, out_valid, parity_errs, drop_cnt, level
  );
endinterface

// File: rtl/noc_local_ingress.sv
// Local NoC ingress: parity-checks incoming flits and queues good ones in a
// show-ahead FIFO with early backpressure and saturating error/drop counters.
module noc_local_ingress #(
  parameter int unsigned HDR_SZ  = 2,
  parameter int unsigned PL_SZ   = 16,
  parameter int unsigned ADDR_SZ = 4,
  parameter int unsigned DEPTH   = 4
) (
  input logic              clk,
  input logic              reset,
  noc_local_ingress_if.slave bus
);
  localparam int unsigned W  = HDR_SZ + PL_SZ + ADDR_SZ;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [W-2:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_nxt;
  logic          busy_q;
  logic [3:0]    perr_q;
  logic [3:0]    drop_q;
  logic          parity_ok;
  logic          good;
  logic          full;
  logic          pop;
  logic          push;

  // Accept/pop decisions and next occupancy
  always_comb begin
    parity_ok = (bus.item_in[W-1] == ^bus.item_in[W-2:0]);
    good      = bus.req && parity_ok;
    full      = (level_q == LW'(DEPTH));
    pop       = (level_q != '0) && bus.out_ready;
    push      = good && (!full || pop);
    level_nxt = level_q;
    if (push && !pop) begin
      level_nxt = level_q + LW'(1);
    end else if (pop && !push) begin
      level_nxt = level_q - LW'(1);
    end
  end

  // Pointers, occupancy, backpressure flag and saturating counters
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level_q <= '0;
      busy_q <= 1'b1;
      perr_q <= '0;
      drop_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      level_q <= level_nxt;
      // One entry of slack so a req already in flight still fits
      busy_q <= (level_nxt >= LW'(DEPTH - 1));
      if (bus.req && !parity_ok && perr_q != 4'hF) perr_q <= perr_q + 4'd1;
      if (good && full && !pop && drop_q != 4'hF) drop_q <= drop_q + 4'd1;
    end
  end

  // FIFO storage, not cleared by reset; parity bit is stripped on write
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= bus.item_in[W-2:0];
  end

  assign bus.out_flit     = mem[rd_ptr];
  assign bus.out_dest     = mem[rd_ptr][ADDR_SZ-1:0];
  assign bus.out_valid    = (level_q != '0);
  assign bus.level        = level_q;
  assign bus.channel_busy = busy_q;
  assign bus.parity_errs  = perr_q;
  assign bus.drop_cnt     = drop_q;
endmodule

// File: tb/tb_noc_local_ingress.sv
// Bench for noc_local_ingress: queue scoreboard of accepted flits plus directed scenarios.
module tb_noc_local_ingress;
  localparam int unsigned HDR_SZ  = 2;
  localparam int unsigned PL_SZ   = 16;
  localparam int unsigned ADDR_SZ = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned W       = HDR_SZ + PL_SZ + ADDR_SZ;
  localparam int unsigned HW      = HDR_SZ - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  noc_local_ingress_if #(.HDR_SZ(HDR_SZ), .PL_SZ(PL_SZ), .ADDR_SZ(ADDR_SZ), .DEPTH(DEPTH)) bus ();

  noc_local_ingress #(.HDR_SZ(HDR_SZ), .PL_SZ(PL_SZ), .ADDR_SZ(ADDR_SZ), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-2:0] exp_q [$];
  int           perr_m = 0;
  int           drop_m = 0;
  logic         busy_m = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] make_flit(input logic [PL_SZ-1:0] pl,
                                              input logic [ADDR_SZ-1:0] d, input logic bad);
    logic [HW-1:0] h;
    logic [W-2:0]  body;
    h = HW'($urandom);
    body = {h, pl, d};
    return {(^body) ^ bad, body};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] f);
    bus.item_in = f;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
  endtask

  // Reference model, sampled mid-cycle: checks current state, then applies this cycle's events
  always @(negedge clk) begin
    logic         pop_m;
    logic         good_m;
    logic         push_m;
    logic [W-2:0] head;
    logic [ADDR_SZ-1:0] head_dest;
    if (reset) begin
      exp_q.delete();
      perr_m = 0;
      drop_m = 0;
      busy_m = 1'b1;
    end else begin
      check_eq("level", 64'(bus.level), 64'(exp_q.size()));
      check_eq("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      check_eq("channel_busy", 64'(bus.channel_busy), 64'(busy_m));
      check_eq("parity_errs", 64'(bus.parity_errs), 64'(perr_m));
      check_eq("drop_cnt", 64'(bus.drop_cnt), 64'(drop_m));
      pop_m = (exp_q.size() != 0) && bus.out_ready;
      if (pop_m) begin
        head = exp_q[0];
        head_dest = head[ADDR_SZ-1:0];
        check_eq("head_flit", 64'(bus.out_flit), 64'(head));
        check_eq("head_dest", 64'(bus.out_dest), 64'(head_dest));
      end
      good_m = bus.req && (bus.item_in[W-1] == ^bus.item_in[W-2:0]);
      if (bus.req && !good_m && perr_m < 15) perr_m++;
      push_m = good_m && ((exp_q.size() < DEPTH) || pop_m);
      if (good_m && !push_m && drop_m < 15) drop_m++;
      if (pop_m) void'(exp_q.pop_front());
      if (push_m) exp_q.push_back(bus.item_in[W-2:0]);
      busy_m = (exp_q.size() >= DEPTH - 1);
    end
  end

  initial begin
    int sent;
    bus.item_in = '0;
    bus.req = 1'b0;
    bus.out_ready = 1'b0;

    // Reset: busy asserted, FIFO empty; busy drops on first edge out of reset
    bus.item_in = make_flit(16'hDEAD, 4'd2, 1'b0);
    bus.req = 1'b1;
    repeat (3) tick();
    bus.req = 1'b0;
    check_eq("rst_busy", 64'(bus.channel_busy), 64'd1);
    check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_level", 64'(bus.level), 64'd0);
    reset = 1'b0;
    tick();
    check_eq("rst_busy_clear", 64'(bus.channel_busy), 64'd0);

    // Single flit with immediate drain
    bus.out_ready = 1'b1;
    send(make_flit(16'h1234, 4'd1, 1'b0));
    check_eq("single_valid", 64'(bus.out_valid), 64'd1);
    check_eq("single_payload", 64'(bus.out_flit[ADDR_SZ +: PL_SZ]), 64'h1234);
    check_eq("single_dest", 64'(bus.out_dest), 64'd1);
    tick();
    check_eq("single_valid_off", 64'(bus.out_valid), 64'd0);
    check_eq("single_level", 64'(bus.level), 64'd0);

    // Parity errors, saturating at 15
    send(make_flit(16'h5555, 4'd3, 1'b1));
    check_eq("perr_one", 64'(bus.parity_errs), 64'd1);
    check_eq("perr_no_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 20; i++) send(make_flit(PL_SZ'($urandom), ADDR_SZ'($urandom), 1'b1));
    check_eq("perr_sat", 64'(bus.parity_errs), 64'd15);

    // req low with arbitrary data changes nothing
    bus.item_in = make_flit(16'hFFFF, 4'hF, 1'b1);
    repeat (2) tick();
    check_eq("idle_level", 64'(bus.level), 64'd0);

    // Fill with downstream stalled, then overflow
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(make_flit(PL_SZ'(16'h0A00 + i), ADDR_SZ'(i), 1'b0));
      tick();
    end
    check_eq("fill_level", 64'(bus.level), 64'd4);
    check_eq("fill_busy", 64'(bus.channel_busy), 64'd1);
    send(make_flit(16'h0BAD, 4'd9, 1'b0));
    check_eq("overflow_drop", 64'(bus.drop_cnt), 64'd1);
    check_eq("overflow_level", 64'(bus.level), 64'd4);

    // Push and pop together while full
    bus.out_ready = 1'b1;
    send(make_flit(16'h0A04, 4'd4, 1'b0));
    bus.out_ready = 1'b0;
    check_eq("fullpp_level", 64'(bus.level), 64'd4);
    check_eq("fullpp_drop", 64'(bus.drop_cnt), 64'd1);
    check_eq("fullpp_head", 64'(bus.out_flit[ADDR_SZ +: PL_SZ]), 64'h0A01);

    // Drain
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && bus.level != 0; i++) tick();
    check_eq("drain1_empty", 64'(bus.level), 64'd0);

    // Ordered stream with random stalls, honouring channel_busy
    sent = 0;
    for (int c = 0; c < 400 && sent < 12; c++) begin
      bus.out_ready = 1'($urandom);
      if (!bus.channel_busy) begin
        bus.item_in = make_flit(PL_SZ'(sent), ADDR_SZ'(sent), 1'b0);
        bus.req = 1'b1;
        sent++;
      end else begin
        bus.req = 1'b0;
      end
      tick();
    end
    bus.req = 1'b0;
    check_eq("stream_sent", 64'(sent), 64'd12);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && bus.level != 0; i++) tick();
    check_eq("stream_empty", 64'(bus.level), 64'd0);
    check_eq("stream_no_drop", 64'(bus.drop_cnt), 64'd1);

    // Reset mid-stream
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(make_flit(PL_SZ'(16'h0C00 + i), ADDR_SZ'(i), 1'b0));
    check_eq("mid_level3", 64'(bus.level), 64'd3);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("mid_rst_level", 64'(bus.level), 64'd0);
    check_eq("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mid_rst_perr", 64'(bus.parity_errs), 64'd0);
    check_eq("mid_rst_drop", 64'(bus.drop_cnt), 64'd0);
    check_eq("mid_rst_busy", 64'(bus.channel_busy), 64'd1);
    tick();
    check_eq("mid_busy_clear", 64'(bus.channel_busy), 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
